codec_config_sequencer: RTL and testbench

//  Drives the codec control-port SPI shifter (16-bit word, DATA/TRG/RDY handshake).

---
 rtl/codec_config_sequencer_pkg.sv | 43 ++++
 rtl/codec_init_rom.sv | 31 +++
 rtl/codec_config_sequencer.sv | 138 +++++++++++++
 tb/tb_codec_config_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_config_sequencer_pkg.sv
// Shared types and codec register words for the codec control-port sequencer.
// Words are {7-bit register address, 9-bit data}.
package codec_config_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_LOAD,
        ST_TRIG,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP,
        ST_IDLE
    } state_t;

    // Cycles, counted from the TRG cycle, within which the shifter must drop RDY.
    localparam int unsigned BUSY_WINDOW = 4;

    localparam logic [15:0] REG_RESET  = 16'h1E00;
    localparam logic [15:0] REG_PWR    = 16'h0C00;
    localparam logic [15:0] REG_LIN    = 16'h0117;
    localparam logic [15:0] REG_LHP    = 16'h0479;
    localparam logic [15:0] REG_RHP    = 16'h0679;
    localparam logic [15:0] REG_APATH  = 16'h0812;
    localparam logic [15:0] REG_DPATH  = 16'h0A00;
    localparam logic [15:0] REG_IFACE  = 16'h0E01;
    localparam logic [15:0] REG_SRATE  = 16'h1000;
    localparam logic [15:0] REG_ACTIVE = 16'h1201;

    localparam logic [6:0] ADDR_LHP_VOL = 7'h02;
    localparam logic [6:0] ADDR_RHP_VOL = 7'h03;

    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (BUSY_WINDOW > m) m = BUSY_WINDOW;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/codec_init_rom.sv
// Combinational init-table lookup; indices at or beyond N_INIT read as zero.
module codec_init_rom
    import codec_config_sequencer_pkg::*;
#(
    parameter int unsigned DATASIZE = 16,
    parameter int unsigned N_INIT   = 10
) (
    input  logic [7:0]          idx,
    output logic [DATASIZE-1:0] word
);

    logic [15:0] entry;

    always_comb begin
        case (idx)
            8'd0:    entry = REG_RESET;
            8'd1:    entry = REG_PWR;
            8'd2:    entry = REG_LIN;
            8'd3:    entry = REG_LHP;
            8'd4:    entry = REG_RHP;
            8'd5:    entry = REG_APATH;
            8'd6:    entry = REG_DPATH;
            8'd7:    entry = REG_IFACE;
            8'd8:    entry = REG_SRATE;
            8'd9:    entry = REG_ACTIVE;
            default: entry = '0;
        endcase
        word = (32'(idx) < N_INIT) ? DATASIZE'(entry) : '0;
    end

endmodule

// File: rtl/codec_config_sequencer.sv
// Powers up the codec through the SPI shifter: startup delay, init table, then
// arbitrated runtime register writes from the user port.
module codec_config_sequencer
    import codec_config_sequencer_pkg::*;
#(
    parameter int unsigned DATASIZE       = 16,
    parameter int unsigned N_INIT         = 10,
    parameter int unsigned STARTUP_CYCLES = 1200,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                CLK,
    input  logic                RESET,
    output logic [DATASIZE-1:0] SPI_DATA,
    output logic                SPI_TRG,
    input  logic                SPI_RDY,
    input  logic [DATASIZE-1:0] USER_DATA,
    input  logic                USER_VALID,
    output logic                USER_READY,
    input  logic                REINIT,
    output logic                INIT_DONE,
    output logic                BUSY,
    output logic                ERROR,
    output logic [7:0]          WORD_IDX
);

    localparam int unsigned CNT_W = cnt_width(STARTUP_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // The TRG cycle is part of the busy window, so WAIT_BUSY itself is one shorter.
    localparam logic [CNT_W-1:0] BUSY_LAST    = CNT_W'(BUSY_WINDOW - 2);
    localparam logic [7:0]       LAST_IDX     = 8'(N_INIT - 1);

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [DATASIZE-1:0] user_word, rom_word;
    logic                reinit_pending, reinit_req;
    logic                restart, gap_end, error_set, accept;

    codec_init_rom #(
        .DATASIZE (DATASIZE),
        .N_INIT   (N_INIT)
    ) u_rom (
        .idx  (WORD_IDX),
        .word (rom_word)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_STARTUP;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        reinit_req = reinit_pending || REINIT;
        gap_end    = (state == ST_GAP) && (cnt >= GAP_LAST);
        error_set  = 1'b0;
        case (state)
            ST_STARTUP:
                if (!REINIT && cnt >= STARTUP_LAST) state_next = ST_LOAD;
            ST_LOAD:
                state_next = ST_TRIG;
            ST_TRIG:
                state_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY:
                if (!SPI_RDY) begin
                    state_next = ST_WAIT_DONE;
                end else if (cnt >= BUSY_LAST) begin
                    state_next = ST_GAP;
                    error_set  = 1'b1;
                end
            ST_WAIT_DONE:
                if (SPI_RDY) begin
                    state_next = ST_GAP;
                end else if (cnt >= TIMEOUT_LAST) begin
                    state_next = ST_GAP;
                    error_set  = 1'b1;
                end
            ST_GAP:
                if (gap_end) begin
                    if (reinit_req)                          state_next = ST_STARTUP;
                    else if (INIT_DONE || WORD_IDX == LAST_IDX) state_next = ST_IDLE;
                    else                                     state_next = ST_LOAD;
                end
            ST_IDLE:
                if (REINIT)          state_next = ST_STARTUP;
                else if (USER_VALID) state_next = ST_LOAD;
            default:
                state_next = ST_STARTUP;
        endcase
        // Staying in STARTUP on REINIT must still restart the delay count.
        restart  = (state_next == ST_STARTUP) && ((state != ST_STARTUP) || REINIT);
        if (restart || state_next != state) cnt_next = '0;
        else if (cnt == '1)                 cnt_next = cnt;
        else                                cnt_next = cnt + 1'b1;
    end

    always_comb begin
        SPI_TRG    = (state == ST_TRIG) && !RESET;
        USER_READY = (state == ST_IDLE) && !REINIT && !RESET;
        BUSY       = (state != ST_IDLE) || RESET;
        accept     = USER_VALID && USER_READY;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            SPI_DATA       <= '0;
            user_word      <= '0;
            INIT_DONE      <= 1'b0;
            ERROR          <= 1'b0;
            WORD_IDX       <= '0;
            reinit_pending <= 1'b0;
        end else begin
            if (accept) user_word <= USER_DATA;
            if (state == ST_LOAD) SPI_DATA <= INIT_DONE ? user_word : rom_word;
            if (error_set) ERROR <= 1'b1;
            if (restart) begin
                INIT_DONE      <= 1'b0;
                ERROR          <= 1'b0;
                WORD_IDX       <= '0;
                reinit_pending <= 1'b0;
            end else begin
                if (REINIT) reinit_pending <= 1'b1;
                if (gap_end && !INIT_DONE) begin
                    if (WORD_IDX == LAST_IDX) INIT_DONE <= 1'b1;
                    else                      WORD_IDX  <= WORD_IDX + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Directed bench for codec_config_sequencer with a behavioural SPI shifter and
// a scoreboard of expected control words.
module tb_codec_config_sequencer;

    localparam int unsigned DATASIZE       = 16;
    localparam int unsigned N_INIT         = 10;
    localparam int unsigned STARTUP_CYCLES = 1200;
    localparam int unsigned GAP_CYCLES     = 16;
    localparam int unsigned TIMEOUT_CYCLES = 1024;
    localparam int          SHIFT_CYCLES   = 18;
    localparam int          STALL_CYCLES   = 1100;

    logic                CLK = 1'b0;
    logic                RESET = 1'b1;
    logic [DATASIZE-1:0] SPI_DATA;
    logic                SPI_TRG;
    logic                SPI_RDY = 1'b1;
    logic [DATASIZE-1:0] USER_DATA = '0;
    logic                USER_VALID = 1'b0;
    logic                USER_READY;
    logic                REINIT = 1'b0;
    logic                INIT_DONE;
    logic                BUSY;
    logic                ERROR;
    logic [7:0]          WORD_IDX;

    int checks = 0;
    int errors = 0;
    int early_ready = 0;
    int busy_cnt = 0;
    int ignore_idx = -1;
    int stall_idx = -1;
    int n;

    logic [DATASIZE-1:0] exp_q[$];
    logic [DATASIZE-1:0] init_words [N_INIT] = '{
        16'h1E00, 16'h0C00, 16'h0117, 16'h0479, 16'h0679,
        16'h0812, 16'h0A00, 16'h0E01, 16'h1000, 16'h1201
    };

    codec_config_sequencer #(
        .DATASIZE       (DATASIZE),
        .N_INIT         (N_INIT),
        .STARTUP_CYCLES (STARTUP_CYCLES),
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SPI_DATA   (SPI_DATA),
        .SPI_TRG    (SPI_TRG),
        .SPI_RDY    (SPI_RDY),
        .USER_DATA  (USER_DATA),
        .USER_VALID (USER_VALID),
        .USER_READY (USER_READY),
        .REINIT     (REINIT),
        .INIT_DONE  (INIT_DONE),
        .BUSY       (BUSY),
        .ERROR      (ERROR),
        .WORD_IDX   (WORD_IDX)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_words(input int first, input int last);
        for (int i = first; i <= last; i++) exp_q.push_back(init_words[i]);
    endtask

    task automatic wait_trg(input int idx, input int budget, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!(SPI_TRG && (idx < 0 || int'(WORD_IDX) == idx)) && cnt < budget);
        check("trg_seen", {31'd0, SPI_TRG}, 32'd1);
    endtask

    task automatic wait_rdy(input logic lvl, input int budget);
        int c = 0;
        while (SPI_RDY !== lvl && c < budget) begin
            tick();
            c++;
        end
        check("rdy_level", {31'd0, SPI_RDY}, {31'd0, lvl});
    endtask

    task automatic wait_init_done(input int budget);
        int c = 0;
        while (!INIT_DONE && c < budget) begin
            tick();
            c++;
        end
        check("init_done", {31'd0, INIT_DONE}, 32'd1);
    endtask

    task automatic pulse_reinit();
        REINIT = 1'b1;
        tick();
        REINIT = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_spi_data", 32'(SPI_DATA), 32'd0);
        check("rst_spi_trg", {31'd0, SPI_TRG}, 32'd0);
        check("rst_init_done", {31'd0, INIT_DONE}, 32'd0);
        check("rst_error", {31'd0, ERROR}, 32'd0);
        check("rst_word_idx", 32'(WORD_IDX), 32'd0);
        check("rst_user_ready", {31'd0, USER_READY}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd1);
    endtask

    // Behavioural shifter: drops RDY the cycle after TRG, raises it again later.
    always @(posedge CLK) begin
        if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) SPI_RDY <= 1'b1;
        end else if (SPI_TRG === 1'b1 && !(int'(WORD_IDX) == ignore_idx && !INIT_DONE)) begin
            SPI_RDY  <= 1'b0;
            busy_cnt <= (int'(WORD_IDX) == stall_idx && !INIT_DONE) ? STALL_CYCLES : SHIFT_CYCLES;
        end
    end

    // Scoreboard: every TRG must carry the next expected word.
    always @(posedge CLK) begin
        #1;
        if (!INIT_DONE && USER_READY) early_ready++;
        if (SPI_TRG === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_trg", {31'd0, SPI_TRG}, 32'd0);
            else check("spi_data", 32'(SPI_DATA), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and full init sequence, with a user write held throughout.
        repeat (3) tick();
        check_reset_values();
        push_words(0, 9);
        USER_DATA  = 16'h0579;
        USER_VALID = 1'b1;
        exp_q.push_back(16'h0579);
        RESET = 1'b0;
        // The last reset edge is cycle 1; TRG lands in cycle STARTUP_CYCLES+2.
        wait_trg(-1, STARTUP_CYCLES + 50, n);
        check("first_trg_cycle", 32'(n), 32'(STARTUP_CYCLES + 1));
        wait_rdy(1'b0, 10);
        wait_rdy(1'b1, 100);
        wait_trg(-1, 100, n);
        check("gap_latency", 32'(n), 32'(GAP_CYCLES + 2));
        check("word1_idx", 32'(WORD_IDX), 32'd1);
        wait_init_done(1000);
        check("init_error", {31'd0, ERROR}, 32'd0);
        check("init_last_idx", 32'(WORD_IDX), 32'(N_INIT - 1));
        check("ready_after_init", {31'd0, USER_READY}, 32'd1);
        check("idle_busy", {31'd0, BUSY}, 32'd0);
        check("no_early_ready", 32'(early_ready), 32'd0);
        tick();
        USER_VALID = 1'b0;
        check("ready_in_load", {31'd0, USER_READY}, 32'd0);
        tick();
        check("user_trg_latency", {31'd0, SPI_TRG}, 32'd1);
        check("user_trg_data", 32'(SPI_DATA), 32'h0579);
        wait_rdy(1'b0, 10);
        wait_rdy(1'b1, 100);
        repeat (GAP_CYCLES + 1) tick();
        check("idle_after_user", {31'd0, BUSY}, 32'd0);
        check("queue_empty_1", 32'(exp_q.size()), 32'd0);

        // REINIT beats a simultaneous user request; shifter ignores word 3.
        push_words(0, 9);
        ignore_idx = 3;
        USER_DATA  = 16'hBEEF;
        USER_VALID = 1'b1;
        REINIT     = 1'b1;
        #1;
        check("ready_vs_reinit", {31'd0, USER_READY}, 32'd0);
        tick();
        REINIT     = 1'b0;
        USER_VALID = 1'b0;
        check("reinit_done_clr", {31'd0, INIT_DONE}, 32'd0);
        check("reinit_idx_clr", 32'(WORD_IDX), 32'd0);
        check("reinit_busy", {31'd0, BUSY}, 32'd1);
        wait_trg(3, STARTUP_CYCLES + 500, n);
        repeat (3) tick();
        check("err_before_window", {31'd0, ERROR}, 32'd0);
        tick();
        check("busy_window_err", {31'd0, ERROR}, 32'd1);
        ignore_idx = -1;
        wait_init_done(1000);
        check("error_sticky", {31'd0, ERROR}, 32'd1);
        check("queue_empty_3", 32'(exp_q.size()), 32'd0);

        // Shifter stalls on word 6 beyond the WAIT_DONE timeout.
        push_words(0, 9);
        stall_idx = 6;
        pulse_reinit();
        check("reinit_err_clr", {31'd0, ERROR}, 32'd0);
        wait_trg(6, STARTUP_CYCLES + 500, n);
        n = 0;
        while (!ERROR && n < int'(TIMEOUT_CYCLES) + 100) begin
            tick();
            n++;
        end
        check("done_timeout_cycle", 32'(n), 32'(TIMEOUT_CYCLES + 2));
        wait_init_done(3000);
        stall_idx = -1;
        check("queue_empty_4", 32'(exp_q.size()), 32'd0);

        // REINIT during word 5: word completes, then startup and full rerun.
        push_words(0, 5);
        push_words(0, 9);
        pulse_reinit();
        check("reinit5_err_clr", {31'd0, ERROR}, 32'd0);
        wait_trg(5, STARTUP_CYCLES + 500, n);
        repeat (4) tick();
        pulse_reinit();
        check("inflight_idx", 32'(WORD_IDX), 32'd5);
        wait_rdy(1'b1, 100);
        repeat (GAP_CYCLES + 1) tick();
        check("restart_idx", 32'(WORD_IDX), 32'd0);
        check("restart_done", {31'd0, INIT_DONE}, 32'd0);
        check("restart_busy", {31'd0, BUSY}, 32'd1);
        wait_trg(-1, STARTUP_CYCLES + 50, n);
        check("restart_trg_cycle", 32'(n), 32'(STARTUP_CYCLES + 1));
        wait_init_done(1000);
        check("queue_empty_5", 32'(exp_q.size()), 32'd0);

        // RESET while waiting for the shifter to finish.
        exp_q.push_back(init_words[0]);
        pulse_reinit();
        wait_trg(0, STARTUP_CYCLES + 50, n);
        repeat (3) tick();
        RESET = 1'b1;
        #1;
        check("trg_in_reset", {31'd0, SPI_TRG}, 32'd0);
        check("busy_in_reset", {31'd0, BUSY}, 32'd1);
        tick();
        check_reset_values();
        push_words(0, 9);
        RESET = 1'b0;
        wait_trg(-1, STARTUP_CYCLES + 50, n);
        check("post_reset_trg", 32'(n), 32'(STARTUP_CYCLES + 1));
        wait_init_done(1000);
        check("post_reset_err", {31'd0, ERROR}, 32'd0);
        check("queue_empty_6", 32'(exp_q.size()), 32'd0);
        check("no_early_ready_end", 32'(early_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
